pipeline_valid_gen: RTL

Forward-direction companion to the stage can-go chain. It tracks a valid token for each pipeline register (ID, EXE, MEM, WB) and advances tokens when the can-go chain permits. It inserts bubbles where an upstream stage is stalled but its downstream stage drains, and kills wrong-path tokens on branch and exception flushes. It also produces a per-cycle retire strobe and free-running retire and bubble counters for performance monitoring.

---
 rtl/pipeline_valid_gen.sv | 115 +++++++++++
 1 files changed

// File: rtl/pipeline_valid_gen.sv
// Valid-token tracker for the ID/EXE/MEM/WB pipeline registers, driven by the
// stage can-go chain, with flush kills, a retire strobe and performance counters.
module pipeline_valid_gen #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 in_Clock,
    input  logic                 in_Reset_N,
    input  logic                 in_IFValid,
    input  logic                 in_IFCanGo,
    input  logic                 in_IDCanGo,
    input  logic                 in_EXECanGo,
    input  logic                 in_MEMCanGo,
    input  logic                 in_WBCanGo,
    input  logic                 in_BranchFlush,
    input  logic                 in_ExcFlush,
    input  logic                 in_CntClear,
    output logic                 out_IDValid,
    output logic                 out_EXEValid,
    output logic                 out_MEMValid,
    output logic                 out_WBValid,
    output logic                 out_Retire,
    output logic [CNT_WIDTH-1:0] out_RetireCnt,
    output logic [CNT_WIDTH-1:0] out_BubbleCnt
);

    logic                 idValid;
    logic                 exeValid;
    logic                 memValid;
    logic                 wbValid;
    logic                 idNext;
    logic                 exeNext;
    logic                 memNext;
    logic                 wbNext;
    logic                 branchKill;
    logic                 earlyKill;
    logic                 retire;
    logic                 bubble;
    logic [CNT_WIDTH-1:0] retireCnt;
    logic [CNT_WIDTH-1:0] bubbleCnt;

    // Kill beats load, load beats bubble, bubble beats hold.
    function automatic logic stageNext(
        input logic kill,
        input logic upGo,
        input logic upValid,
        input logic ownGo,
        input logic cur
    );
        logic nxt;
        nxt = cur;
        if (kill) begin
            nxt = 1'b0;
        end else if (upGo) begin
            nxt = upValid;
        end else if (ownGo) begin
            nxt = 1'b0;
        end
        return nxt;
    endfunction

    // A branch only counts once EXE actually advances; MEM still takes the branch.
    assign branchKill = in_BranchFlush & in_EXECanGo;
    assign earlyKill  = in_ExcFlush | branchKill;

    always_comb begin
        idNext  = stageNext(earlyKill,   in_IFCanGo,  in_IFValid, in_IDCanGo,  idValid);
        exeNext = stageNext(earlyKill,   in_IDCanGo,  idValid,    in_EXECanGo, exeValid);
        memNext = stageNext(in_ExcFlush, in_EXECanGo, exeValid,   in_MEMCanGo, memValid);
        wbNext  = stageNext(in_ExcFlush, in_MEMCanGo, memValid,   in_WBCanGo,  wbValid);
    end

    always_ff @(posedge in_Clock or negedge in_Reset_N) begin
        if (!in_Reset_N) begin
            idValid  <= 1'b0;
            exeValid <= 1'b0;
            memValid <= 1'b0;
            wbValid  <= 1'b0;
        end else begin
            idValid  <= idNext;
            exeValid <= exeNext;
            memValid <= memNext;
            wbValid  <= wbNext;
        end
    end

    assign retire = wbValid & in_WBCanGo & in_Reset_N;
    assign bubble = in_WBCanGo & ~wbValid;

    // The flush-cycle retire is still counted: WB leaves before the kill lands.
    always_ff @(posedge in_Clock or negedge in_Reset_N) begin
        if (!in_Reset_N) begin
            retireCnt <= '0;
            bubbleCnt <= '0;
        end else if (in_CntClear) begin
            retireCnt <= '0;
            bubbleCnt <= '0;
        end else begin
            if (retire) begin
                retireCnt <= retireCnt + CNT_WIDTH'(1);
            end
            if (bubble) begin
                bubbleCnt <= bubbleCnt + CNT_WIDTH'(1);
            end
        end
    end

    assign out_IDValid   = idValid;
    assign out_EXEValid  = exeValid;
    assign out_MEMValid  = memValid;
    assign out_WBValid   = wbValid;
    assign out_Retire    = retire;
    assign out_RetireCnt = retireCnt;
    assign out_BubbleCnt = bubbleCnt;

endmodule
